// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-Lite bus bundle between a master and the memory slave.
// The master drives the address and data-phase inputs; the slave returns ready, response and read data.
interface ahb_lite_mem_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_mem_slave.sv
// Word-addressed AHB-Lite memory slave: WAIT_STATES+1 cycle OKAY data phase, two-cycle ERROR.
// Stalls the bus via HREADYOUT; accepts back-to-back transfers with write->read forwarding.
module ahb_lite_mem_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic HCLK,
  input  logic HRESETn,
  ahb_lite_mem_slave_if.slave bus
);
  localparam int         AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  logic            wr_q;
  logic            rdy_q;
  logic            resp_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [MEM_DEPTH];

  logic            cap;
  logic            cap_ok;
  logic [AW-1:0]   cap_idx;
  logic [31:0]     cap_rdata;

  always_comb begin
    cap     = bus.HSEL & bus.HREADY & ((bus.HTRANS == 2'b10) | (bus.HTRANS == 2'b11));
    cap_ok  = (bus.HSIZE == 3'b010) && (bus.HADDR[1:0] == 2'b00) &&
              ({2'b00, bus.HADDR[31:2]} < 32'(MEM_DEPTH));
    cap_idx = bus.HADDR[AW+1:2];
    // A write finishing on this very edge has not reached the array yet.
    cap_rdata = (state == S_DATA && wr_q && idx_q == cap_idx) ? bus.HWDATA : mem[cap_idx];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      rdy_q   <= 1'b1;
      resp_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_DATA;
            rdy_q <= 1'b1;
            if (!wr_q) rdata_q <= mem[idx_q];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state  <= S_ERR2;
          rdy_q  <= 1'b1;
          resp_q <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all present HREADYOUT=1, so a new address phase may land here.
          if (cap) begin
            idx_q <= cap_idx;
            wr_q  <= bus.HWRITE;
            if (!cap_ok) begin
              state  <= S_ERR1;
              rdy_q  <= 1'b0;
              resp_q <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state  <= S_DATA;
              rdy_q  <= 1'b1;
              resp_q <= 1'b0;
              if (!bus.HWRITE) rdata_q <= cap_rdata;
            end else begin
              state  <= S_WAIT;
              cnt    <= WS_INIT;
              rdy_q  <= 1'b0;
              resp_q <= 1'b0;
            end
          end else begin
            state  <= S_IDLE;
            rdy_q  <= 1'b1;
            resp_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // No reset on the array: contents survive HRESETn, and reset forces IDLE so no write slips through.
  always_ff @(posedge HCLK) begin
    if (state == S_DATA && wr_q) mem[idx_q] <= bus.HWDATA;
  end

  assign bus.HREADYOUT = rdy_q;
  assign bus.HRESP     = resp_q;
  assign bus.HRDATA    = rdata_q;
endmodule
